fifo_wr_arb: RTL and testbench

Round-robin write-port arbiter that shares the write side of one `fifo_2clk` instance among `NREQ` requesters in the `wclk` domain. It uses the FIFO's `w_emptycount` for flow control, so no word is ever written into a full FIFO. It can keep the grant with one requester until that requester's multi-word packet is complete. It sits directly in front of `fifo_2clk`: `wt`, `wtdata` and `w_emptycount` connect one-to-one to the FIFO write port.

---
 rtl/fifo_wr_arb.sv | 143 ++++++++++++++
 tb/tb_fifo_wr_arb.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arb
// Description : Round-robin write-port arbiter in front of a fifo_2clk, using
//               w_emptycount for flow control. Optional packet locking is
//               enabled with the FIFO_WR_ARB_LOCK_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arb #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic                      wclk,
   input  logic                      aw_rst_n,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ*WIDTH-1:0]     req_data,
   input  logic [NREQ-1:0]           req_last,
   output logic [NREQ-1:0]           gnt,
   input  logic [CNT_W-1:0]          w_emptycount,
   output logic                      wt,
   output logic [WIDTH-1:0]          wtdata,
   output logic [$clog2(NREQ)-1:0]   owner,
   output logic                      busy
);

   localparam int IDX_W = $clog2(NREQ);
   localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NREQ - 1);

   logic                 wt_q, wt_d;
   logic [WIDTH-1:0]     wtdata_q, wtdata_d;
   logic [IDX_W-1:0]     owner_q, owner_d;
   logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;

   logic [CNT_W-1:0]     w_space;
   logic                 w_locked;
   logic [NREQ-1:0]      w_rr_gnt;
   logic [IDX_W-1:0]     w_rr_idx;
   logic [IDX_W-1:0]     w_grant_idx;
   logic                 w_accept;
   logic [WIDTH-1:0]     w_sel_data;

   // The write issued last cycle is not yet visible in w_emptycount.
   assign w_space = w_emptycount - CNT_W'(wt_q);

`ifdef FIFO_WR_ARB_LOCK_EN
   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t state_q, state_d;

   assign w_locked = (state_q == ST_LOCKED);
`else
   logic unused_req_last;

   assign w_locked        = 1'b0;
   assign unused_req_last = ^req_last;
`endif

   always_comb begin : p_rr_search
      logic [IDX_W-1:0] idx;
      logic             found;
      w_rr_gnt = '0;
      w_rr_idx = rr_ptr_q;
      idx      = rr_ptr_q;
      found    = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (idx == C_LAST_IDX) ? '0 : idx + 1'b1;
         if (!found && req[idx]) begin
            found         = 1'b1;
            w_rr_gnt[idx] = 1'b1;
            w_rr_idx      = idx;
         end
      end
   end

   always_comb begin
      gnt         = '0;
      w_grant_idx = w_rr_idx;
      if (aw_rst_n && (w_space != '0)) begin
         if (w_locked) begin
            w_grant_idx  = owner_q;
            gnt[owner_q] = req[owner_q];
         end else begin
            gnt = w_rr_gnt;
         end
      end
   end

   assign w_accept = |(req & gnt);

   always_comb begin
      w_sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_grant_idx == IDX_W'(i)) begin
            w_sel_data = req_data[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      wt_d     = w_accept;
      wtdata_d = w_accept ? w_sel_data  : wtdata_q;
      owner_d  = w_accept ? w_grant_idx : owner_q;
      rr_ptr_d = w_accept ? w_grant_idx : rr_ptr_q;
`ifdef FIFO_WR_ARB_LOCK_EN
      state_d  = state_q;
      if (w_accept) begin
         state_d = req_last[w_grant_idx] ? ST_IDLE : ST_LOCKED;
      end
`endif
   end

   always_ff @(posedge wclk or negedge aw_rst_n) begin
      if (!aw_rst_n) begin
         wt_q     <= 1'b0;
         wtdata_q <= '0;
         owner_q  <= '0;
         rr_ptr_q <= C_LAST_IDX;
`ifdef FIFO_WR_ARB_LOCK_EN
         state_q  <= ST_IDLE;
`endif
      end else begin
         wt_q     <= wt_d;
         wtdata_q <= wtdata_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
`ifdef FIFO_WR_ARB_LOCK_EN
         state_q  <= state_d;
`endif
      end
   end

   assign wt     = wt_q;
   assign wtdata = wtdata_q;
   assign owner  = owner_q;
   assign busy   = w_locked;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arb
// Description : Directed scoreboard bench for fifo_wr_arb with a DEPTH=4
//               free-count model standing in for the FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arb;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH) + 1;

`ifdef FIFO_WR_ARB_LOCK_EN
   localparam logic LOCK_ON = 1'b1;
   localparam int   NSTEP   = 4;
   localparam int   N0      = 1;
   int   seq_w    [5] = '{2, 2, 2, 0, 0};
   logic seq_busy [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
`else
   localparam logic LOCK_ON = 1'b0;
   localparam int   NSTEP   = 5;
   localparam int   N0      = 2;
   int   seq_w    [5] = '{2, 0, 2, 0, 2};
   logic seq_busy [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

   logic                    clk   = 1'b0;
   logic                    rst_n = 1'b0;
   logic [NREQ-1:0]         req;
   logic [NREQ*WIDTH-1:0]   req_data;
   logic [NREQ-1:0]         req_last;
   logic [NREQ-1:0]         gnt;
   logic [CNT_W-1:0]        cnt;
   logic                    wt;
   logic [WIDTH-1:0]        wtdata;
   logic [1:0]              owner;
   logic                    busy;
   logic                    rd;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q [$];

   fifo_wr_arb #(
      .NREQ  (NREQ),
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_dut (
      .wclk         (clk),
      .aw_rst_n     (rst_n),
      .req          (req),
      .req_data     (req_data),
      .req_last     (req_last),
      .gnt          (gnt),
      .w_emptycount (cnt),
      .wt           (wt),
      .wtdata       (wtdata),
      .owner        (owner),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // Free-slot model: a write lands one edge after wt, a read frees a slot.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= CNT_W'(DEPTH);
      else        cnt <= cnt - CNT_W'(wt) + CNT_W'(rd && (cnt < CNT_W'(DEPTH)));
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (wt === 1'b1) begin
         if (exp_q.size() == 0) chk("wt_unexpected", 32'(wt), 32'd0);
         else                   chk("wtdata", 32'(wtdata), 32'(exp_q.pop_front()));
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic grant_step(input logic [3:0] r, input logic [3:0] exp_g, input string tag);
      req = r;
      #2;
      chk(tag, 32'(gnt), 32'(exp_g));
      for (int i = 0; i < NREQ; i++) begin
         if (exp_g[i]) exp_q.push_back(req_data[i*WIDTH +: WIDTH]);
      end
      next_cycle();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      next_cycle();
      rst_n = 1'b1;
   endtask

   initial begin : p_main
      logic [3:0] req_v;
      int idx0;
      int idx2;
      req      = 4'b1111;
      req_last = 4'b1111;
      req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      rd       = 1'b0;
      next_cycle();
      chk("rst_gnt",    32'(gnt),    32'd0);
      chk("rst_wt",     32'(wt),     32'd0);
      chk("rst_wtdata", 32'(wtdata), 32'd0);
      chk("rst_owner",  32'(owner),  32'd0);
      chk("rst_busy",   32'(busy),   32'd0);

      // Release with everyone requesting: 0,1,2,3 in turn.
      rst_n = 1'b1;
      grant_step(4'b1111, 4'b0001, "rr_g0");
      grant_step(4'b1110, 4'b0010, "rr_g1");
      grant_step(4'b1100, 4'b0100, "rr_g2");
      grant_step(4'b1000, 4'b1000, "rr_g3");
      grant_step(4'b0000, 4'b0000, "rr_idle");
      chk("rr_owner", 32'(owner), 32'd3);
      grant_step(4'b0000, 4'b0000, "rr_idle2");

      // Fill the FIFO from requester 1 with no reads.
      do_reset();
      for (int k = 0; k < 4; k++) begin
         req_data[15:8] = 8'(8'hB0 + k);
         grant_step(4'b0010, 4'b0010, "full_fill");
      end
      req_data[15:8] = 8'hB4;
      grant_step(4'b0010, 4'b0000, "full_inflight");
      grant_step(4'b0010, 4'b0000, "full_stall");
      rd = 1'b1;
      grant_step(4'b0010, 4'b0000, "full_stall_rd");
      rd = 1'b0;
      grant_step(4'b0010, 4'b0010, "full_one_more");
      grant_step(4'b0010, 4'b0000, "full_again");
      grant_step(4'b0000, 4'b0000, "full_idle");

      // One free slot held for two cycles with two requesters active.
      rd = 1'b1;
      grant_step(4'b0000, 4'b0000, "inf_rd");
      rd = 1'b0;
      req_data[7:0]  = 8'hE0;
      req_data[15:8] = 8'hE1;
      grant_step(4'b0011, 4'b0001, "inf_first");
      grant_step(4'b0011, 4'b0000, "inf_blocked");
      grant_step(4'b0011, 4'b0000, "inf_blocked2");
      req = 4'b0000;

      // Packet from requester 2 while requester 0 waits.
      do_reset();
      req_data[15:8] = 8'hF0;
      grant_step(4'b0010, 4'b0010, "lock_pre");
      rd = 1'b1;
      grant_step(4'b0000, 4'b0000, "lock_gap");
      grant_step(4'b0000, 4'b0000, "lock_gap2");
      idx0  = 0;
      idx2  = 0;
      req_v = 4'b0101;
      for (int s = 0; s < NSTEP; s++) begin
         req_data[7:0]   = 8'(8'hC0 + idx0);
         req_last[0]     = 1'b1;
         req_data[23:16] = 8'(8'hD0 + idx2);
         req_last[2]     = (idx2 == 2);
         chk("lock_busy", 32'(busy), 32'(seq_busy[s]));
         grant_step(req_v, 4'(1 << seq_w[s]), "lock_gnt");
         if (seq_w[s] == 2) idx2++;
         else               idx0++;
         if (idx2 == 3)  req_v[2] = 1'b0;
         if (idx0 == N0) req_v[0] = 1'b0;
      end
      grant_step(4'b0000, 4'b0000, "lock_done");
      chk("lock_busy_end", 32'(busy), 32'd0);
      rd = 1'b0;

      // Reset in the middle of a requester-3 packet.
      do_reset();
      req_data[31:24] = 8'h99;
      req_last        = 4'b0111;
      grant_step(4'b1000, 4'b1000, "mid_word1");
      chk("mid_busy_pre",  32'(busy),  32'(LOCK_ON));
      chk("mid_owner_pre", 32'(owner), 32'd3);
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      chk("mid_busy_rst",  32'(busy),  32'd0);
      chk("mid_owner_rst", 32'(owner), 32'd0);
      chk("mid_gnt_rst",   32'(gnt),   32'd0);
      chk("mid_wt_rst",    32'(wt),    32'd0);
      next_cycle();
      rst_n         = 1'b1;
      req_data[7:0] = 8'h55;
      grant_step(4'b1001, 4'b0001, "mid_restart0");
      grant_step(4'b1000, 4'b1000, "mid_restart3");
      req_data[31:24] = 8'h9A;
      req_last[3]     = 1'b1;
      grant_step(4'b1000, 4'b1000, "mid_last3");
      grant_step(4'b0000, 4'b0000, "mid_idle");
      grant_step(4'b0000, 4'b0000, "mid_idle2");

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
